// File: rtl/pht_pkg.sv
// Shared types and helpers for the PHT write-port controller and its
// saturating-counter arithmetic.
package pht_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Widest counter the helpers below support
    localparam int unsigned MAX_DW = 32;

    // Weakly-not-taken value: 2^(dw-1)-1
    function automatic logic [MAX_DW-1:0] init_val(input int unsigned dw);
        logic [63:0] v;
        v = (64'd1 << (dw - 1)) - 64'd1;
        return v[MAX_DW-1:0];
    endfunction

    // Saturating increment on taken, saturating decrement on not-taken
    function automatic logic [MAX_DW-1:0] sat_next(
        input logic [MAX_DW-1:0] cur,
        input logic              taken,
        input int unsigned       dw
    );
        logic [63:0] top;
        top = (64'd1 << dw) - 64'd1;
        if (taken) begin
            return (cur == top[MAX_DW-1:0]) ? cur : cur + MAX_DW'(1);
        end
        return (cur == '0) ? cur : cur - MAX_DW'(1);
    endfunction

endpackage

// File: rtl/pht_update_writer_if.sv
// Update handshake from branch resolution plus the PHT RMW/write port.
interface pht_update_writer_if #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 2
);
    logic                  upd_valid;
    logic                  upd_ready;
    logic [ADDR_WIDTH-1:0] upd_addr;
    logic                  upd_taken;
    logic [ADDR_WIDTH-1:0] mem_raddr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_wt_en;
    logic [ADDR_WIDTH-1:0] mem_wtaddr;
    logic [DATA_WIDTH-1:0] mem_wtdata;

    // Environment side: requester and PHT memory
    modport master (
        output upd_valid, upd_addr, upd_taken, mem_rdata,
        input  upd_ready, mem_raddr, mem_wt_en, mem_wtaddr, mem_wtdata
    );

    // Writer side
    modport slave (
        input  upd_valid, upd_addr, upd_taken, mem_rdata,
        output upd_ready, mem_raddr, mem_wt_en, mem_wtaddr, mem_wtdata
    );
endinterface

// File: rtl/sat_counter_next.sv
// Combinational next value of a DATA_WIDTH-bit saturating counter.
module sat_counter_next
    import pht_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 2
) (
    input  logic [DATA_WIDTH-1:0] cur,
    input  logic                  taken,
    output logic [DATA_WIDTH-1:0] nxt
);

    // Saturating step toward the resolved direction
    always_comb begin
        nxt = DATA_WIDTH'(sat_next(MAX_DW'(cur), taken, DATA_WIDTH));
    end

endmodule

// File: rtl/pht_update_writer.sv
// Owns the PHT write port: initial sweep to weakly-not-taken, then
// pipelined read-modify-write of saturating counters on updates.
module pht_update_writer
    import pht_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 2
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                clr,
    output logic                init_done,
    pht_update_writer_if.slave  bus
);

    localparam logic [ADDR_WIDTH-1:0] PTR_MAX  = '1;
    localparam logic [DATA_WIDTH-1:0] INIT_VAL = DATA_WIDTH'(init_val(DATA_WIDTH));

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  req_v_q, req_v_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic                  req_taken_q, req_taken_d;
    logic                  wt_en_q, wt_en_d;
    logic [ADDR_WIDTH-1:0] wt_addr_q, wt_addr_d;
    logic [DATA_WIDTH-1:0] wt_data_q, wt_data_d;
    logic [DATA_WIDTH-1:0] cur, nxt;
    logic                  accept;

    assign bus.upd_ready  = (state_q == RUN) && !clr;
    assign init_done      = (state_q == RUN);
    assign bus.mem_raddr  = req_addr_q;
    assign bus.mem_wt_en  = wt_en_q;
    assign bus.mem_wtaddr = wt_addr_q;
    assign bus.mem_wtdata = wt_data_q;
    assign accept         = bus.upd_valid && bus.upd_ready;

    // Forward the in-flight write: it lands only at the end of this cycle
    always_comb begin
        cur = bus.mem_rdata;
        if (wt_en_q && (wt_addr_q == req_addr_q)) begin
            cur = wt_data_q;
        end
    end

    sat_counter_next #(.DATA_WIDTH(DATA_WIDTH)) u_sat (
        .cur   (cur),
        .taken (req_taken_q),
        .nxt   (nxt)
    );

    // Next-state: sweep in INIT, two-stage RMW in RUN, clr aborts to INIT
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        req_v_d     = 1'b0;
        req_addr_d  = req_addr_q;
        req_taken_d = req_taken_q;
        wt_en_d     = 1'b0;
        wt_addr_d   = wt_addr_q;
        wt_data_d   = wt_data_q;
        if (clr) begin
            state_d = INIT;
            ptr_d   = '0;
        end else begin
            case (state_q)
                INIT: begin
                    wt_en_d   = 1'b1;
                    wt_addr_d = ptr_q;
                    wt_data_d = INIT_VAL;
                    if (ptr_q == PTR_MAX) begin
                        state_d = RUN;
                        ptr_d   = '0;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
                RUN: begin
                    if (req_v_q) begin
                        wt_en_d   = 1'b1;
                        wt_addr_d = req_addr_q;
                        wt_data_d = nxt;
                    end
                    if (accept) begin
                        req_v_d     = 1'b1;
                        req_addr_d  = bus.upd_addr;
                        req_taken_d = bus.upd_taken;
                    end
                end
                default: state_d = INIT;
            endcase
        end
    end

    // State and registered write-port outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= INIT;
            ptr_q       <= '0;
            req_v_q     <= 1'b0;
            req_addr_q  <= '0;
            req_taken_q <= 1'b0;
            wt_en_q     <= 1'b0;
            wt_addr_q   <= '0;
            wt_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            req_v_q     <= req_v_d;
            req_addr_q  <= req_addr_d;
            req_taken_q <= req_taken_d;
            wt_en_q     <= wt_en_d;
            wt_addr_q   <= wt_addr_d;
            wt_data_q   <= wt_data_d;
        end
    end

endmodule

// File: tb/tb_pht_update_writer.sv
// Directed bench: default 32x2 table plus a 4x1 build for the W=1 case.
module tb_pht_update_writer;

    logic clk = 1'b0;
    logic rstn;
    logic clr;
    logic clr1;
    logic init_done;
    logic init_done1;
    logic preload;
    int   n_total = 0;
    int   n_bad   = 0;

    logic [1:0] mem  [32];
    logic       mem1 [4];

    always #5 clk = ~clk;

    pht_update_writer_if #(.ADDR_WIDTH(5), .DATA_WIDTH(2)) bus  ();
    pht_update_writer_if #(.ADDR_WIDTH(2), .DATA_WIDTH(1)) bus1 ();

    pht_update_writer #(.ADDR_WIDTH(5), .DATA_WIDTH(2)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (clr),
        .init_done (init_done),
        .bus       (bus.slave)
    );

    pht_update_writer #(.ADDR_WIDTH(2), .DATA_WIDTH(1)) dut1 (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (clr1),
        .init_done (init_done1),
        .bus       (bus1.slave)
    );

    // PHT models: sync write, async read, preloaded to non-init values
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) mem[i] <= 2'd3;
            for (int i = 0; i < 4; i++) mem1[i] <= 1'b1;
        end else begin
            if (bus.mem_wt_en)  mem[bus.mem_wtaddr]   <= bus.mem_wtdata;
            if (bus1.mem_wt_en) mem1[bus1.mem_wtaddr] <= bus1.mem_wtdata;
        end
    end
    assign bus.mem_rdata  = mem[bus.mem_raddr];
    assign bus1.mem_rdata = mem1[bus1.mem_raddr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep_check(input string tag);
        for (int i = 0; i < 32; i++) begin
            tick();
            chk({tag, "_en"},   32'(bus.mem_wt_en), 32'd1);
            chk({tag, "_addr"}, 32'(bus.mem_wtaddr), 32'(i));
            chk({tag, "_data"}, 32'(bus.mem_wtdata), 32'd1);
            chk({tag, "_done"}, 32'(init_done), (i == 31) ? 32'd1 : 32'd0);
            chk({tag, "_rdy"},  32'(bus.upd_ready), (i == 31) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        int cnt;
        rstn = 1'b0; clr = 1'b0; clr1 = 1'b0; preload = 1'b1;
        bus.upd_valid  = 1'b0; bus.upd_addr  = '0; bus.upd_taken  = 1'b0;
        bus1.upd_valid = 1'b0; bus1.upd_addr = '0; bus1.upd_taken = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_en",   32'(bus.mem_wt_en), 32'd0);
        chk("rst_addr", 32'(bus.mem_wtaddr), 32'd0);
        chk("rst_data", 32'(bus.mem_wtdata), 32'd0);
        chk("rst_done", 32'(init_done), 32'd0);
        chk("rst_rdy",  32'(bus.upd_ready), 32'd0);
        preload = 1'b0;
        @(negedge clk);
        rstn = 1'b1;

        // 1: initial sweep
        sweep_check("t1");
        tick();
        chk("t1_idle_en", 32'(bus.mem_wt_en), 32'd0);
        cnt = 0;
        for (int i = 0; i < 32; i++) if (mem[i] !== 2'd1) cnt++;
        chk("t1_mem_all1", 32'(cnt), 32'd0);
        cnt = 0;
        for (int i = 0; i < 4; i++) if (mem1[i] !== 1'b0) cnt++;
        chk("t4_w1_init0", 32'(cnt), 32'd0);
        chk("t4_w1_done", 32'(init_done1), 32'd1);

        // 2: addr 5 taken x3, spaced out
        for (int k = 0; k < 3; k++) begin
            bus.upd_valid = 1'b1; bus.upd_addr = 5'd5; bus.upd_taken = 1'b1;
            tick();
            bus.upd_valid = 1'b0;
            chk("t2_en_lat1", 32'(bus.mem_wt_en), 32'd0);
            tick();
            chk("t2_en",   32'(bus.mem_wt_en), 32'd1);
            chk("t2_addr", 32'(bus.mem_wtaddr), 32'd5);
            chk("t2_data", 32'(bus.mem_wtdata), (k == 0) ? 32'd2 : 32'd3);
            tick();
            chk("t2_mem5", 32'(mem[5]), (k == 0) ? 32'd2 : 32'd3);
        end

        // 3: back-to-back on addr 9: T, NT, T
        bus.upd_valid = 1'b1; bus.upd_addr = 5'd9; bus.upd_taken = 1'b1;
        tick();
        bus.upd_taken = 1'b0;
        tick();
        chk("t3_w0", 32'(bus.mem_wtdata), 32'd2);
        chk("t3_a0", 32'(bus.mem_wtaddr), 32'd9);
        bus.upd_taken = 1'b1;
        tick();
        chk("t3_w1", 32'(bus.mem_wtdata), 32'd1);
        bus.upd_valid = 1'b0;
        tick();
        chk("t3_w2", 32'(bus.mem_wtdata), 32'd2);
        chk("t3_en", 32'(bus.mem_wt_en), 32'd1);
        tick();
        chk("t3_mem9", 32'(mem[9]), 32'd2);

        // 4: addr 0 not-taken x2 (floor), W=1 taken x2 on addr 1 (ceiling)
        bus.upd_valid  = 1'b1; bus.upd_addr  = 5'd0; bus.upd_taken  = 1'b0;
        bus1.upd_valid = 1'b1; bus1.upd_addr = 2'd1; bus1.upd_taken = 1'b1;
        tick();
        tick();
        chk("t4_w0",  32'(bus.mem_wtdata), 32'd0);
        chk("t4_b0",  32'(bus1.mem_wtdata), 32'd1);
        bus.upd_valid = 1'b0; bus1.upd_valid = 1'b0;
        tick();
        chk("t4_w1",  32'(bus.mem_wtdata), 32'd0);
        chk("t4_b1",  32'(bus1.mem_wtdata), 32'd1);
        chk("t4_b1a", 32'(bus1.mem_wtaddr), 32'd1);
        tick();
        chk("t4_mem0",  32'(mem[0]), 32'd0);
        chk("t4_mem1_1", 32'(mem1[1]), 32'd1);

        // 5: clr right after accepting addr 7 taken
        bus.upd_valid = 1'b1; bus.upd_addr = 5'd7; bus.upd_taken = 1'b1;
        tick();
        bus.upd_valid = 1'b0;
        clr = 1'b1;
        #1;
        chk("t5_rdy_clr", 32'(bus.upd_ready), 32'd0);
        tick();
        clr = 1'b0;
        chk("t5_no_wr", 32'(bus.mem_wt_en), 32'd0);
        chk("t5_rdy", 32'(bus.upd_ready), 32'd0);
        chk("t5_done", 32'(init_done), 32'd0);
        sweep_check("t5");
        tick();
        chk("t5_mem7", 32'(mem[7]), 32'd1);
        chk("t5_mem0", 32'(mem[0]), 32'd1);

        // 6: async reset mid-sweep
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (13) tick();
        chk("t6_pre_addr", 32'(bus.mem_wtaddr), 32'd12);
        chk("t6_pre_en",   32'(bus.mem_wt_en), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("t6_async_en",   32'(bus.mem_wt_en), 32'd0);
        chk("t6_async_addr", 32'(bus.mem_wtaddr), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        sweep_check("t6");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/pht_update_writer.md
Name: pht_update_writer

Overview:
- Owns the single write port of a branch-predictor pattern history table built from distributed memory: synchronous write, asynchronous read, no reset.
- After reset or clear, sweeps every entry to the weakly-not-taken value.
- Then accepts branch-resolution updates over a valid/ready handshake and performs a pipelined read-modify-write of a saturating counter.
- Sits between the branch resolution unit and the PHT memory; the predictor's lookup read ports are separate and unaffected.

Parameters:
ADDR_WIDTH, 5, table index width; table depth = 2^ADDR_WIDTH
DATA_WIDTH, 2, saturating counter width (>= 1)

Ports:
clk  in  1  clock; all state updates on rising edge
rstn  in  1  reset, asynchronous, active-low
clr  in  1  single-cycle pulse: drop pending update, restart init sweep
upd_valid  in  1  update request valid
upd_ready  out  1  update request accepted when valid & ready
upd_addr  in  ADDR_WIDTH  table index to update
upd_taken  in  1  resolved direction: 1 = taken
init_done  out  1  high while in RUN (sweep complete)
mem_raddr  out  ADDR_WIDTH  read address to PHT RMW read port
mem_rdata  in  DATA_WIDTH  asynchronous read data for mem_raddr
mem_wt_en  out  1  PHT write enable (registered)
mem_wtaddr  out  ADDR_WIDTH  PHT write address (registered)
mem_wtdata  out  DATA_WIDTH  PHT write data (registered)

Behaviour:
- Reset (rstn=0, async): state=INIT, ptr=0, req_v=0, mem_wt_en=0, mem_wtaddr=0, mem_wtdata=0, init_done=0, upd_ready=0.
- Constant INIT_VAL = 2^(DATA_WIDTH-1)-1 (weakly not-taken; 1 for W=2, 0 for W=1).
- INIT state:
  - Each cycle registers mem_wt_en=1, mem_wtaddr=ptr, mem_wtdata=INIT_VAL, then ptr+1.
  - After the cycle with ptr=2^ADDR_WIDTH-1, go to RUN. The sweep lasts exactly 2^ADDR_WIDTH cycles.
  - upd_ready=0 throughout; req_v held 0.
- RUN state: init_done=1; upd_ready = !clr.
- Stage 1: on accept, register req_v=1, req_addr, req_taken. Otherwise req_v=0.
- Stage 2 (req_v=1):
  - mem_raddr=req_addr; cur = mem_rdata.
  - Forwarding: if mem_wt_en=1 and mem_wtaddr==req_addr, cur = mem_wtdata (that write lands at the end of this cycle).
  - nxt = taken ? (cur==all-ones ? cur : cur+1) : (cur==0 ? 0 : cur-1).
  - Register mem_wt_en=1, mem_wtaddr=req_addr, mem_wtdata=nxt.
  - When req_v=0, register mem_wt_en=0; mem_wtaddr and mem_wtdata hold.
- mem_raddr = req_addr in all states (don't-care when req_v=0).
- Latency: accept at edge E, write presented after E+1, memory updated at E+2. Throughput 1 update/cycle, including back-to-back updates to the same index.
- clr=1 in any state:
  - Next state INIT, ptr=0, req_v=0; the pending stage-2 request is discarded, not written.
  - A write already registered on mem_wt_* completes normally, then the sweep overwrites it.
  - clr during INIT restarts the sweep from 0.
- upd_valid while upd_ready=0: ignored. The requester holds it (standard valid/ready; no combinational path from upd_valid to upd_ready).
- Address wrap: ptr is ADDR_WIDTH+1 bits or compared against max before increment; no aliasing.
- Reset mid-sweep or mid-RMW: everything aborts immediately; the sweep restarts after deassertion.

Decomposition:
- Package pht_pkg: INIT_VAL function of DATA_WIDTH, state enum {INIT, RUN}, saturating-counter next-value function.
- One sub-module is natural: sat_counter_next (combinational; inputs cur, taken; output nxt; parameter DATA_WIDTH), reusable by the predictor's speculative-update path.

Test Plan:
Bench memory: 32x2 register array, synchronous write, asynchronous read, preloaded with 3 everywhere; defaults A=5, W=2.
1. Release reset, idle 32 cycles -> exactly 32 writes, addr 0..31 in order, data 1; init_done rises on cycle 32; all entries read 1.
2. After init, update addr 5 taken x3 -> entry 5 goes 1,2,3,3 (saturates); writes appear 2 cycles after each accept.
3. Back-to-back: addr 9 taken then addr 9 not-taken then taken, consecutive cycles -> writes 2,1,2 (forwarding exercised; no stale read).
4. Not-taken x2 on addr 0 from 1 -> 0,0 (floor saturation); W=1 build: INIT_VAL=0, taken->1, taken->1.
5. clr asserted the cycle after accepting addr 7 taken -> no write to 7; sweep restarts at 0; upd_ready=0 for 32 cycles; entry 7 ends at 1.
6. Assert rstn=0 mid-sweep at ptr=12 -> mem_wt_en drops immediately (async); after release, the sweep restarts at addr 0 and completes 32 writes.
